main_sort: RTL and testbench

Packet sorter on Avalon-ST: accepts one packet of 1..MAX_PKT_LEN unsigned words on the sink, sorts them ascending, and emits them as one packet on the source. It works on one packet at a time: the sink is held off while sorting and streaming out. It sits inline in a streaming datapath. The companion SystemVerilog interface `sort_avst_if` bundles the sink and source signals for benches and parent modules.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_avst_if.sv | 37 +++
 rtl/sort_engine.sv | 77 +++++++
 rtl/main_sort.sv | 148 ++++++++++++++
 tb/tb_main_sort.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the packet sorter.
// Imported by the sorter top and its bubble-sort engine.
package sort_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSort = 2'd1,
    StSend = 2'd2
  } sort_state_e;

  // Width of a counter that must hold the value max_len itself.
  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/sort_avst_if.sv
// Bundles the sorter's Avalon-ST sink and source signals.
// Used by parent modules and benches.
interface sort_avst_if #(
  parameter int unsigned DWIDTH = 8
) (
  input logic clk,
  input logic srst
);

  logic [DWIDTH-1:0] snk_data;
  logic              snk_startofpacket;
  logic              snk_endofpacket;
  logic              snk_valid;
  logic              snk_ready;
  logic [DWIDTH-1:0] src_data;
  logic              src_startofpacket;
  logic              src_endofpacket;
  logic              src_valid;
  logic              src_ready;

  modport dut (
    input  clk, srst,
    input  snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
    output snk_ready,
    output src_data, src_startofpacket, src_endofpacket, src_valid,
    input  src_ready
  );

  modport host (
    input  clk, srst,
    output snk_data, snk_startofpacket, snk_endofpacket, snk_valid,
    input  snk_ready,
    input  src_data, src_startofpacket, src_endofpacket, src_valid,
    output src_ready
  );

endinterface

// File: rtl/sort_engine.sv
// Word storage plus an in-place bubble sort doing one compare/swap per cycle.
// done_o flags the cycle that performs the final compare of the final pass.
module sort_engine
  import sort_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 16,
  parameter int unsigned CW          = cnt_width(MAX_PKT_LEN),
  parameter int unsigned AW          = addr_width(MAX_PKT_LEN)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              sort_en_i,
  input  logic [CW-1:0]     len_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              done_o
);

  logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     pass_q, pass_d;
  logic [CW-1:0]     last_idx;
  logic [AW-1:0]     lo_idx, hi_idx;
  logic [DWIDTH-1:0] lo_val, hi_val;
  logic              swap;
  logic              pass_end;

  always_comb begin
    last_idx = len_i - CW'(2);
    lo_idx   = j_q[AW-1:0];
    hi_idx   = AW'(j_q + CW'(1));
    lo_val   = mem_q[lo_idx];
    hi_val   = mem_q[hi_idx];
    swap     = sort_en_i && (lo_val > hi_val);
    pass_end = (j_q == last_idx);
    done_o   = sort_en_i && pass_end && (pass_q == last_idx);
    rd_data_o = mem_q[rd_addr_i];

    j_d    = j_q;
    pass_d = pass_q;
    if (!sort_en_i) begin
      // Counters sit at zero whenever the engine is idle, ready for the next sort.
      j_d    = '0;
      pass_d = '0;
    end else if (pass_end) begin
      j_d    = '0;
      pass_d = pass_q + CW'(1);
    end else begin
      j_d = j_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      j_q    <= '0;
      pass_q <= '0;
    end else begin
      j_q    <= j_d;
      pass_q <= pass_d;
    end
  end

  // Data storage carries no reset; every packet rewrites what it reads.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end else if (swap) begin
      mem_q[lo_idx] <= hi_val;
      mem_q[hi_idx] <= lo_val;
    end
  end

endmodule

// File: rtl/main_sort.sv
// Avalon-ST packet sorter: receives one packet, sorts it ascending, streams it out.
// The sink is held off from end of receive until the last output word is accepted.
module main_sort
  import sort_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
);

  localparam int unsigned CW = cnt_width(MAX_PKT_LEN);
  localparam int unsigned AW = addr_width(MAX_PKT_LEN);

  sort_state_e       state_q, state_d;
  logic [CW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     len_q, len_d;
  logic              in_pkt_q, in_pkt_d;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              sort_en;
  logic              sort_done;
  logic [DWIDTH-1:0] rd_data;
  logic              snk_hs;

  assign snk_ready_o = (state_q == StIdle);
  assign snk_hs      = snk_valid_i && snk_ready_o;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    len_d    = len_q;
    in_pkt_d = in_pkt_q;
    wr_en    = 1'b0;
    wr_addr  = wptr_q[AW-1:0];
    sort_en  = 1'b0;
    src_valid_o         = 1'b0;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (snk_hs) begin
          if (snk_startofpacket_i) begin
            // A sop always (re)starts the packet at index 0.
            wr_en    = 1'b1;
            wr_addr  = '0;
            wptr_d   = CW'(1);
            in_pkt_d = 1'b1;
            if (snk_endofpacket_i) begin
              len_d    = CW'(1);
              in_pkt_d = 1'b0;
              state_d  = StSend;
            end
          end else if (in_pkt_q) begin
            // Words past capacity are dropped but their eop still closes the packet.
            if (wptr_q < CW'(MAX_PKT_LEN)) begin
              wr_en  = 1'b1;
              wptr_d = wptr_q + CW'(1);
            end
            if (snk_endofpacket_i) begin
              len_d    = wptr_d;
              in_pkt_d = 1'b0;
              state_d  = StSort;
            end
          end
        end
      end

      StSort: begin
        sort_en = 1'b1;
        if (sort_done) begin
          state_d = StSend;
        end
      end

      StSend: begin
        src_valid_o         = 1'b1;
        src_data_o          = rd_data;
        src_startofpacket_o = (rptr_q == '0);
        src_endofpacket_o   = (rptr_q == len_q - CW'(1));
        if (src_ready_i) begin
          if (src_endofpacket_o) begin
            rptr_d  = '0;
            wptr_d  = '0;
            state_d = StIdle;
          end else begin
            rptr_d = rptr_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      len_q    <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      len_q    <= len_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  sort_engine #(
    .DWIDTH      (DWIDTH),
    .MAX_PKT_LEN (MAX_PKT_LEN),
    .CW          (CW),
    .AW          (AW)
  ) u_engine (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (snk_data_i),
    .sort_en_i (sort_en),
    .len_i     (len_q),
    .rd_addr_i (rptr_q[AW-1:0]),
    .rd_data_o (rd_data),
    .done_o    (sort_done)
  );

endmodule

// File: tb/tb_main_sort.sv
// Randomised self-checking bench for main_sort against a sorted-copy reference model.
module tb_main_sort;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 16;

  typedef logic [DW-1:0] word_t;
  typedef word_t         wq_t[$];
  typedef bit            bq_t[$];

  logic clk = 1'b0;
  logic srst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sort_avst_if #(.DWIDTH(DW)) bus (.clk(clk), .srst(srst));

  main_sort #(.DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .snk_data_i          (bus.snk_data),
    .snk_startofpacket_i (bus.snk_startofpacket),
    .snk_endofpacket_i   (bus.snk_endofpacket),
    .snk_valid_i         (bus.snk_valid),
    .snk_ready_o         (bus.snk_ready),
    .src_data_o          (bus.src_data),
    .src_startofpacket_o (bus.src_startofpacket),
    .src_endofpacket_o   (bus.src_endofpacket),
    .src_valid_o         (bus.src_valid),
    .src_ready_i         (bus.src_ready)
  );

  // Reference: the first ML words of the packet, sorted ascending.
  function automatic wq_t model_sort(input wq_t pkt);
    wq_t e;
    for (int i = 0; i < pkt.size() && i < ML; i++) e.push_back(pkt[i]);
    e.sort();
    return e;
  endfunction

  function automatic bit same(input wq_t a, input wq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit flags_ok(input bq_t s, input bq_t e);
    if (s.size() == 0 || s.size() != e.size()) return 1'b0;
    for (int i = 0; i < s.size(); i++)
      if (s[i] != (i == 0) || e[i] != (i == s.size() - 1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sort_lat(input int n);
    int m;
    m = (n > ML) ? ML : n;
    return (m - 1) * (m - 1);
  endfunction

  task automatic push_word(input word_t d, input bit sop, input bit eop, input int duty,
                           inout int tmo);
    int g;
    g = 0;
    while ($urandom_range(1, 100) > duty && g < 1000) begin
      bus.snk_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    bus.snk_data          = d;
    bus.snk_startofpacket = sop;
    bus.snk_endofpacket   = eop;
    bus.snk_valid         = 1'b1;
    g = 0;
    while (bus.snk_ready !== 1'b1 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) tmo++;
    @(negedge clk);
    bus.snk_valid         = 1'b0;
    bus.snk_startofpacket = 1'b0;
    bus.snk_endofpacket   = 1'b0;
  endtask

  task automatic push_pkt(input wq_t pkt, input int duty, inout int tmo);
    for (int i = 0; i < pkt.size(); i++)
      push_word(pkt[i], i == 0, i == pkt.size() - 1, duty, tmo);
  endtask

  // Starts on the falling edge right after the eop handshake.
  task automatic collect(input int rdy_duty, output wq_t got, output bq_t s, output bq_t e,
                         output int lat, output int ocyc, output bit held_bad,
                         output bit rdy_bad, output bit tmo);
    word_t pd;
    bit    ps, pe, have, done;
    got = {}; s = {}; e = {};
    lat = 0; ocyc = 0; held_bad = 0; rdy_bad = 0; tmo = 0; have = 0; done = 0;
    pd = '0; ps = 0; pe = 0;
    while (bus.src_valid !== 1'b1 && lat < 400) begin
      if (bus.snk_ready !== 1'b0) rdy_bad = 1;
      @(negedge clk);
      lat++;
    end
    if (lat >= 400) begin
      tmo = 1;
      return;
    end
    while (!done && ocyc < 3000) begin
      if (bus.src_valid === 1'b1) begin
        if (have && (bus.src_data !== pd || bus.src_startofpacket !== ps ||
                     bus.src_endofpacket !== pe)) held_bad = 1;
        if (bus.snk_ready !== 1'b0) rdy_bad = 1;
        bus.src_ready = ($urandom_range(1, 100) <= rdy_duty);
        if (bus.src_ready) begin
          got.push_back(bus.src_data);
          s.push_back(bus.src_startofpacket);
          e.push_back(bus.src_endofpacket);
          done = bus.src_endofpacket;
          have = 0;
        end else begin
          have = 1; pd = bus.src_data; ps = bus.src_startofpacket; pe = bus.src_endofpacket;
        end
      end else begin
        bus.src_ready = 1'b0;
        have = 0;
      end
      @(negedge clk);
      ocyc++;
    end
    bus.src_ready = 1'b0;
    if (!done) tmo = 1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    checks++; if (bus.src_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b want=0", bus.src_valid); end
    checks++; if (bus.src_startofpacket !== 1'b0 || bus.src_endofpacket !== 1'b0) begin
      failures++; $display("FAIL reset_sop_eop got=%b%b want=00",
                           bus.src_startofpacket, bus.src_endofpacket); end
    checks++; if (bus.src_data !== '0) begin failures++;
      $display("FAIL reset_data got=%h want=00", bus.src_data); end
    checks++; if (bus.snk_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b want=1", bus.snk_ready); end
  endtask

  // Fixed-pattern packet with full and latency/ready checks.
  task automatic test_fixed(input string name, input wq_t pkt, input int duty, input int rdy);
    wq_t got, exp;
    bq_t s, e;
    int  lat, ocyc, ptmo;
    bit  held_bad, rdy_bad, tmo;
    ptmo = 0;
    push_pkt(pkt, duty, ptmo);
    collect(rdy, got, s, e, lat, ocyc, held_bad, rdy_bad, tmo);
    exp = model_sort(pkt);
    checks++; if (ptmo != 0 || tmo) begin failures++;
      $display("FAIL %s_timeout push=%0d collect=%0b want=0,0", name, ptmo, tmo); end
    checks++; if (lat != sort_lat(pkt.size())) begin failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, sort_lat(pkt.size())); end
    checks++; if (!same(got, exp)) begin failures++;
      $display("FAIL %s_data got=%p want=%p", name, got, exp); end
    checks++; if (!flags_ok(s, e)) begin failures++;
      $display("FAIL %s_flags sop=%p eop=%p want sop first/eop last only", name, s, e); end
    checks++; if (rdy_bad || held_bad) begin failures++;
      $display("FAIL %s_hold snk_ready_high=%0b data_moved=%0b want=0,0", name, rdy_bad,
               held_bad); end
    if (rdy == 100) begin
      checks++; if (ocyc != exp.size()) begin failures++;
        $display("FAIL %s_burst got=%0d cycles want=%0d", name, ocyc, exp.size()); end
    end
    checks++; if (bus.snk_ready !== 1'b1 || bus.src_valid !== 1'b0) begin failures++;
      $display("FAIL %s_after ready=%b valid=%b want=1,0", name, bus.snk_ready,
               bus.src_valid); end
  endtask

  task automatic test_single();
    wq_t got;
    bq_t s, e;
    int  lat, ocyc, ptmo;
    bit  held_bad, rdy_bad, tmo;
    ptmo = 0;
    push_word(8'hA5, 1'b1, 1'b1, 100, ptmo);
    collect(100, got, s, e, lat, ocyc, held_bad, rdy_bad, tmo);
    checks++; if (tmo || ptmo != 0 || lat != 0) begin failures++;
      $display("FAIL single_latency got=%0d tmo=%0b want=0", lat, tmo); end
    checks++; if (got.size() != 1 || got[0] !== 8'hA5 || s[0] != 1'b1 || e[0] != 1'b1) begin
      failures++; $display("FAIL single_word got=%p sop=%p eop=%p want='{a5} 1 1", got, s, e);
    end
  endtask

  // Words before any sop are discarded; words past ML are dropped but eop still ends it.
  task automatic test_presop_overflow();
    wq_t pkt;
    int  ptmo;
    ptmo = 0;
    push_word(8'h00, 1'b0, 1'b0, 100, ptmo);
    push_word(8'h01, 1'b0, 1'b1, 100, ptmo);
    checks++; if (bus.snk_ready !== 1'b1 || ptmo != 0) begin failures++;
      $display("FAIL presop_ignored ready=%b want=1", bus.snk_ready); end
    for (int i = 0; i < ML + 2; i++) pkt.push_back(word_t'($urandom_range(2, 255)));
    test_fixed("overflow", pkt, 70, 100);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 100; p++) begin
      wq_t pkt;
      int  n;
      n = $urandom_range(2, ML);
      for (int i = 0; i < n; i++) pkt.push_back(word_t'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      test_fixed($sformatf("b2b%0d", p), pkt, $urandom_range(1, 100), $urandom_range(25, 100));
    end
  endtask

  task automatic test_reset_mid_sort();
    wq_t pkt;
    int  ptmo, seen;
    ptmo = 0;
    for (int i = 0; i < ML; i++) pkt.push_back(word_t'($urandom_range(0, 255)));
    push_pkt(pkt, 100, ptmo);
    repeat (20) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checks++; if (bus.src_valid !== 1'b0 || bus.src_data !== '0 ||
                  bus.src_startofpacket !== 1'b0 || bus.src_endofpacket !== 1'b0) begin
      failures++; $display("FAIL rst_sort_outputs valid=%b data=%h sop=%b eop=%b want=0,00,0,0",
                           bus.src_valid, bus.src_data, bus.src_startofpacket,
                           bus.src_endofpacket); end
    checks++; if (bus.snk_ready !== 1'b1) begin failures++;
      $display("FAIL rst_sort_ready got=%b want=1", bus.snk_ready); end
    seen = 0;
    repeat (300) begin
      if (bus.src_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin failures++;
      $display("FAIL rst_sort_leak got=%0d valid cycles want=0", seen); end
    test_fixed("post_rst", '{8'd3, 8'd1, 8'd2}, 100, 100);
  endtask

  initial begin
    wq_t desc;
    srst = 1'b1;
    bus.snk_data = '0; bus.snk_startofpacket = 1'b0; bus.snk_endofpacket = 1'b0;
    bus.snk_valid = 1'b0; bus.src_ready = 1'b0;
    test_reset();
    test_fixed("basic4", '{8'h30, 8'h10, 8'h40, 8'h20}, 100, 100);
    for (int i = 0; i < ML; i++) desc.push_back(word_t'(8'hFF - i));
    test_fixed("desc16", desc, 100, 100);
    test_fixed("equal2", '{8'h55, 8'h55}, 30, 100);
    test_single();
    test_presop_overflow();
    desc = {};
    for (int i = 0; i < ML; i++) desc.push_back(word_t'($urandom_range(0, 255)));
    test_fixed("stall", desc, 100, 40);
    test_back_to_back();
    test_reset_mid_sort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
